// File: rtl/scan_cfg_loader_pkg.sv
// Types and default sizes shared by the scan configuration loader files.
package scan_cfg_loader_pkg;
`include "cfg_defs.v"

   typedef enum logic [1:0] {
      ST_IDLE = `CFG_IDLE,
      ST_LOAD = `CFG_LOAD,
      ST_DONE = `CFG_DONE
   } cfg_state_e;

   localparam int DEF_CHAIN_LEN  = `CFG_CLB_CHAIN_LEN;
   localparam int DEF_WORD_WIDTH = 8;
   localparam int DEF_CNT_WIDTH  = 5;
endpackage

// File: rtl/scan_cfg_if.sv
// Host stream, chain serial pins and status of the scan configuration loader.
interface scan_cfg_if #(
   parameter int WORD_WIDTH = 8
);
   logic                  start;
   logic                  abort;
   logic [WORD_WIDTH-1:0] cfg_data;
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic                  scan_en;
   logic                  scan_out;
   logic                  scan_in;
   logic [WORD_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  busy;
   logic                  done;

   modport slave (
      input  start, abort, cfg_data, cfg_valid, scan_in,
      output cfg_ready, scan_en, scan_out, rd_data, rd_valid, busy, done
   );

   modport master (
      output start, abort, cfg_data, cfg_valid, scan_in,
      input  cfg_ready, scan_en, scan_out, rd_data, rd_valid, busy, done
   );
endinterface

// File: rtl/cfg_defs.v
// Shared scan-chain constants: loader state encodings and the per-CLB chain length
// from which multi-CLB fabric chain lengths are derived.
`ifndef CFG_DEFS_V
`define CFG_DEFS_V
`define CFG_IDLE 2'd0
`define CFG_LOAD 2'd1
`define CFG_DONE 2'd2
// is_comb bit + connection-mux config + LUT SRAM
`define CFG_CLB_CHAIN_LEN 29
`endif

// File: rtl/scan_deser.sv
// Readback accumulator: packs bits leaving the chain tail into words, LSB first,
// flushing a zero-padded partial word when the load's last bit is captured.
module scan_deser
   import scan_cfg_loader_pkg::*;
#(
   parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  shift_i,
   input  logic                  bit_i,
   input  logic                  last_i,
   output logic [WORD_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o
);
   localparam int KW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(WORD_WIDTH - 1);

   logic [KW-1:0]         k_q, k_d;
   logic [WORD_WIDTH-1:0] acc_q, acc_d, word;
   logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;

   always_comb begin
      acc_d      = acc_q;
      k_d        = k_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      word       = acc_q;
      word[k_q]  = bit_i;
      if (clr_i) begin
         acc_d = '0;
         k_d   = '0;
      end else if (shift_i) begin
         if (last_i || k_q == K_LAST) begin
            rd_data_d  = word;
            rd_valid_d = 1'b1;
            acc_d      = '0;
            k_d        = '0;
         end else begin
            acc_d = word;
            k_d   = k_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q        <= '0;
         acc_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         k_q        <= k_d;
         acc_q      <= acc_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
endmodule

// File: rtl/scan_cfg_loader.sv
// Serializes host configuration words LSB-first onto the CLB scan chain for exactly
// CHAIN_LEN shifts, while reading back the previous chain contents from the tail.
module scan_cfg_loader
   import scan_cfg_loader_pkg::*;
#(
   parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic       clk,
   input  logic       rst,
   scan_cfg_if.slave  bus
);
   localparam logic [CNT_WIDTH-1:0] CL_C  = CNT_WIDTH'(CHAIN_LEN);
   localparam logic [CNT_WIDTH-1:0] WW_C  = CNT_WIDTH'(WORD_WIDTH);
   localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

   cfg_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0]  rem_q, rem_d;
   logic [CNT_WIDTH-1:0]  bcnt_q, bcnt_d;
   logic [CNT_WIDTH-1:0]  avail;
   logic [WORD_WIDTH-1:0] buf_q, buf_d;
   logic                  in_load, shift, accept, launch, kill;

   // rem >= bcnt always holds, so avail is the count of bits not yet buffered
   assign in_load = (state_q == ST_LOAD);
   assign shift   = (bcnt_q != '0);
   assign avail   = rem_q - bcnt_q;
   assign launch  = bus.start && !in_load;
   assign kill    = in_load && bus.abort;
   assign accept  = bus.cfg_valid && bus.cfg_ready;

   assign bus.cfg_ready = in_load && (bcnt_q <= ONE_C) && (avail != '0);
   assign bus.scan_en   = shift;
   assign bus.scan_out  = buf_q[0];
   assign bus.busy      = in_load;
   assign bus.done      = (state_q == ST_DONE);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      bcnt_d  = bcnt_q;
      buf_d   = buf_q;
      unique case (state_q)
         ST_LOAD: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
               rem_d   = '0;
               bcnt_d  = '0;
            end else begin
               if (shift) begin
                  buf_d  = buf_q >> 1;
                  bcnt_d = bcnt_q - 1'b1;
                  rem_d  = rem_q - 1'b1;
                  if (rem_q == ONE_C) state_d = ST_DONE;
               end
               // a word accepted on the last shift of its predecessor refills buf directly
               if (accept) begin
                  buf_d  = bus.cfg_data;
                  bcnt_d = (avail < WW_C) ? avail : WW_C;
               end
            end
         end
         default: begin
            if (bus.start) begin
               state_d = ST_LOAD;
               rem_d   = CL_C;
               bcnt_d  = '0;
               buf_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         bcnt_q  <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         bcnt_q  <= bcnt_d;
         buf_q   <= buf_d;
      end
   end

   scan_deser #(.WORD_WIDTH(WORD_WIDTH)) u_deser (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (launch || kill),
      .shift_i    (shift && in_load && !bus.abort),
      .bit_i      (bus.scan_in),
      .last_i     (rem_q == ONE_C),
      .rd_data_o  (bus.rd_data),
      .rd_valid_o (bus.rd_valid)
   );
endmodule
